bsg_parity_check_segmented: RTL and testbench

//  Receive-side checker for segment-parity-protected links. Accepts a data word plus one parity bit per segment
//  (valid/ready), recomputes per-segment parity, and forwards the data with a per-segment error mask (valid/yumi).

---
 rtl/bsg_parity_check_segmented_pkg.sv | 20 ++
 rtl/bsg_reduce_segmented.sv | 33 +++
 rtl/bsg_parity_check_segmented.sv | 132 +++++++++++++
 tb/tb_bsg_parity_check_segmented.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_parity_check_segmented_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bsg_parity_check_segmented_pkg
// Purpose  : Shared constants and helpers for segmented-parity links. The
//            generator and the checker both use these.
// Revision : 1.0 - initial release
// ============================================================================
package bsg_parity_check_segmented_pkg;

   // Parity polarity selectors
   localparam int parity_even = 0;
   localparam int parity_odd  = 1;

   // Total data width of a segmented word
   function automatic int total_width(input int segments, input int segment_width);
      return segments * segment_width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_reduce_segmented.sv
`default_nettype none
// ============================================================================
// Module   : bsg_reduce_segmented
// Purpose  : Per-segment reduction of a wide word. The word is split into
//            segments_p equal slices, and each slice is reduced to one bit
//            with XOR, AND or OR.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_reduce_segmented
   import bsg_parity_check_segmented_pkg::*;
#(
   parameter int segments_p      = 1,
   parameter int segment_width_p = 1,
   parameter int xor_p           = 1,
   parameter int and_p           = 0
)
(
   input  logic [total_width(segments_p, segment_width_p)-1:0] i,
   output logic [segments_p-1:0]                               o
);

   for (genvar j = 0; j < segments_p; j++) begin : g_seg
      if (xor_p != 0) begin : g_xor
         assign o[j] = ^i[j*segment_width_p +: segment_width_p];
      end else if (and_p != 0) begin : g_and
         assign o[j] = &i[j*segment_width_p +: segment_width_p];
      end else begin : g_or
         assign o[j] = |i[j*segment_width_p +: segment_width_p];
      end
   end

endmodule
`default_nettype wire

// File: rtl/bsg_parity_check_segmented.sv
`default_nettype none
// ============================================================================
// Module   : bsg_parity_check_segmented
// Purpose  : Receive-side segmented parity checker. It holds one output
//            register with a valid/yumi handshake. The output carries the data
//            and a per-segment error mask. The module also keeps sticky error
//            status, the first error mask and a saturating count of error words.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_parity_check_segmented
   import bsg_parity_check_segmented_pkg::*;
#(
   parameter int segments_p      = 4,
   parameter int segment_width_p = 8,
   parameter int odd_p           = parity_even,
   parameter int err_cnt_width_p = 16
)
(
   input  logic                                                clk_i,
   input  logic                                                reset_i,
   input  logic                                                v_i,
   input  logic [total_width(segments_p, segment_width_p)-1:0] data_i,
   input  logic [segments_p-1:0]                               parity_i,
   output logic                                                ready_o,
   output logic                                                v_o,
   output logic [total_width(segments_p, segment_width_p)-1:0] data_o,
   output logic [segments_p-1:0]                               err_o,
   input  logic                                                yumi_i,
   input  logic                                                clear_i,
   output logic                                                sticky_err_o,
   output logic [segments_p-1:0]                               first_err_o,
   output logic [err_cnt_width_p-1:0]                          err_cnt_o
);

   localparam int data_width = total_width(segments_p, segment_width_p);

   // For odd parity, a matching segment has XOR opposite to its parity bit.
   // Folding a constant mask into the XOR covers both polarities.
   localparam logic [segments_p-1:0] polarity_mask =
      (odd_p == parity_odd) ? {segments_p{1'b1}} : {segments_p{1'b0}};

   localparam logic [err_cnt_width_p-1:0] cnt_one = err_cnt_width_p'(1);

   // Bad parameterisations are rejected at elaboration time
   if (segments_p < 1 || segment_width_p < 1) begin : g_param_check
      $error("bsg_parity_check_segmented: segments_p and segment_width_p must be >= 1");
   end

   logic                     word_valid;
   logic [data_width-1:0]    word_data;
   logic [segments_p-1:0]    word_err;
   logic                     sticky_err;
   logic [segments_p-1:0]    first_err;
   logic [err_cnt_width_p-1:0] err_cnt;

   logic [segments_p-1:0]    seg_xor;
   logic [segments_p-1:0]    err_next;
   logic                     accept;

   bsg_reduce_segmented #(
      .segments_p      (segments_p),
      .segment_width_p (segment_width_p),
      .xor_p           (1),
      .and_p           (0)
   ) reduce (
      .i (data_i),
      .o (seg_xor)
   );

   assign err_next = seg_xor ^ parity_i ^ polarity_mask;

   // The slot is free when it is empty or is being drained this cycle
   assign ready_o = ~word_valid | yumi_i;
   assign accept  = v_i & ready_o;

   // Output register: load on accept, empty on yumi with no refill
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         word_valid <= 1'b0;
      end else if (accept) begin
         word_valid <= 1'b1;
      end else if (yumi_i) begin
         word_valid <= 1'b0;
      end
   end

   // Data and error mask need no reset: they are meaningless while invalid
   always_ff @(posedge clk_i) begin
      if (accept) begin
         word_data <= data_i;
         word_err  <= err_next;
      end
   end

   // Error statistics. Clear is applied first, and a same-cycle error word then counts.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sticky_err <= 1'b0;
         first_err  <= '0;
         err_cnt    <= '0;
      end else begin
         if (clear_i) begin
            sticky_err <= 1'b0;
            first_err  <= '0;
            err_cnt    <= '0;
         end
         if (accept && (|err_next)) begin
            sticky_err <= 1'b1;
            if (clear_i || !sticky_err) begin
               first_err <= err_next;
            end
            if (clear_i) begin
               err_cnt <= cnt_one;
            end else if (!(&err_cnt)) begin
               err_cnt <= err_cnt + cnt_one;
            end
         end
      end
   end

   assign v_o          = word_valid;
   assign data_o       = word_data;
   assign err_o        = word_err;
   assign sticky_err_o = sticky_err;
   assign first_err_o  = first_err;
   assign err_cnt_o    = err_cnt;

   // The consumer may only take a word that is present
   yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> word_valid);

endmodule
`default_nettype wire

// File: tb/tb_bsg_parity_check_segmented.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_parity_check_segmented
// Purpose  : Self-checking bench. Three checkers share one stimulus stream:
//            [0] even parity with a 16-bit counter, [1] even parity with a
//            2-bit counter, [2] odd parity with a 16-bit counter. All three
//            use 4 segments of 8 bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_parity_check_segmented;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_i, v_i, yumi_i, clear_i;
   logic [31:0] data_i;
   logic [3:0]  parity_i;

   logic        rdy [3];
   logic        vo  [3];
   logic        stk [3];
   logic [31:0] dout[3];
   logic [3:0]  erro[3];
   logic [3:0]  ferr[3];
   logic [15:0] cnt_a, cnt_c;
   logic [1:0]  cnt_b;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit          m_v;
   logic [31:0] m_data;
   logic [3:0]  m_err   [3];
   bit          m_sticky[3];
   logic [3:0]  m_first [3];
   int          m_cnt   [3];

   bsg_parity_check_segmented #(.segments_p(4), .segment_width_p(8), .odd_p(0), .err_cnt_width_p(16)) dut_a (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .parity_i(parity_i),
      .ready_o(rdy[0]), .v_o(vo[0]), .data_o(dout[0]), .err_o(erro[0]), .yumi_i(yumi_i),
      .clear_i(clear_i), .sticky_err_o(stk[0]), .first_err_o(ferr[0]), .err_cnt_o(cnt_a));

   bsg_parity_check_segmented #(.segments_p(4), .segment_width_p(8), .odd_p(0), .err_cnt_width_p(2)) dut_b (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .parity_i(parity_i),
      .ready_o(rdy[1]), .v_o(vo[1]), .data_o(dout[1]), .err_o(erro[1]), .yumi_i(yumi_i),
      .clear_i(clear_i), .sticky_err_o(stk[1]), .first_err_o(ferr[1]), .err_cnt_o(cnt_b));

   bsg_parity_check_segmented #(.segments_p(4), .segment_width_p(8), .odd_p(1), .err_cnt_width_p(16)) dut_c (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .parity_i(parity_i),
      .ready_o(rdy[2]), .v_o(vo[2]), .data_o(dout[2]), .err_o(erro[2]), .yumi_i(yumi_i),
      .clear_i(clear_i), .sticky_err_o(stk[2]), .first_err_o(ferr[2]), .err_cnt_o(cnt_c));

   function automatic int cnt_of(int k);
      if (k == 0) return int'(cnt_a);
      if (k == 1) return int'(cnt_b);
      return int'(cnt_c);
   endfunction

   function automatic int cnt_max(int k);
      return (k == 1) ? 3 : 65535;
   endfunction

   // Expected error mask, found by counting the ones in each byte.
   // An even checker flags a segment whose ones-count parity differs from its
   // parity bit. An odd checker flags a segment whose ones-count parity equals it.
   function automatic logic [3:0] ref_err(int k, logic [31:0] d, logic [3:0] p);
      logic [3:0] r;
      logic [7:0] seg;
      int ones;
      for (int j = 0; j < 4; j++) begin
         seg  = d[j*8 +: 8];
         ones = $countones(seg);
         r[j] = ((ones % 2) != int'(p[j]));
         if (k == 2) r[j] = ~r[j];
      end
      return r;
   endfunction

   // Advance the model with the current inputs, then step the clock
   task automatic tick();
      bit acc;
      logic [3:0] e;
      acc = v_i && (!m_v || yumi_i);
      if (reset_i) begin
         m_v = 1'b0;
         for (int k = 0; k < 3; k++) begin
            m_sticky[k] = 1'b0; m_first[k] = '0; m_cnt[k] = 0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (clear_i) begin
               m_sticky[k] = 1'b0; m_first[k] = '0; m_cnt[k] = 0;
            end
            if (acc) begin
               e = ref_err(k, data_i, parity_i);
               m_err[k] = e;
               if (e != 0) begin
                  if (!m_sticky[k]) m_first[k] = e;
                  m_sticky[k] = 1'b1;
                  if (m_cnt[k] < cnt_max(k)) m_cnt[k] = m_cnt[k] + 1;
               end
            end
         end
         if (acc) begin
            m_v = 1'b1; m_data = data_i;
         end else if (yumi_i) begin
            m_v = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; v_i = 0; yumi_i = 0; clear_i = 0; data_i = '0; parity_i = '0;
      tick(); tick();
      reset_i = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (vo[k] !== 1'b0 || stk[k] !== 1'b0 || ferr[k] !== 4'b0 || cnt_of(k) != 0 || rdy[k] !== 1'b1) begin
            failures++;
            $display("FAIL reset[%0d]: v_o=%b sticky=%b first=%b cnt=%0d ready=%b, want 0 0 0000 0 1",
                     k, vo[k], stk[k], ferr[k], cnt_of(k), rdy[k]);
         end
      end
   endtask

   task automatic test_clean_word();
      v_i = 1; data_i = 32'h0100FF03; parity_i = 4'b1000;
      tick();
      v_i = 0;
      #1;
      checks++;
      if (vo[0] !== 1'b1 || dout[0] !== 32'h0100FF03 || erro[0] !== 4'b0000 || cnt_a !== 16'd0 || stk[0] !== 1'b0) begin
         failures++;
         $display("FAIL clean_word: v_o=%b data=%h err=%b cnt=%0d sticky=%b, want 1 0100ff03 0000 0 0",
                  vo[0], dout[0], erro[0], cnt_a, stk[0]);
      end
      checks++;
      if (erro[2] !== 4'b1111) begin
         failures++;
         $display("FAIL clean_word_odd: err=%b want 1111", erro[2]);
      end
      yumi_i = 1;
      tick();
      yumi_i = 0;
      #1;
      checks++;
      if (vo[0] !== 1'b0) begin
         failures++;
         $display("FAIL drain: v_o=%b want 0", vo[0]);
      end
   endtask

   task automatic test_error_words();
      v_i = 1; data_i = 32'h0100FF03; parity_i = 4'b1001;
      tick();
      v_i = 0;
      #1;
      checks++;
      if (erro[0] !== 4'b0001 || stk[0] !== 1'b1 || ferr[0] !== 4'b0001 || cnt_a !== 16'd1) begin
         failures++;
         $display("FAIL err_word1: err=%b sticky=%b first=%b cnt=%0d, want 0001 1 0001 1",
                  erro[0], stk[0], ferr[0], cnt_a);
      end
      yumi_i = 1; v_i = 1; parity_i = 4'b1100;
      tick();
      yumi_i = 0; v_i = 0;
      #1;
      checks++;
      if (erro[0] !== 4'b0100 || ferr[0] !== 4'b0001 || cnt_a !== 16'd2 || vo[0] !== 1'b1) begin
         failures++;
         $display("FAIL err_word2: err=%b first=%b cnt=%0d v_o=%b, want 0100 0001 2 1",
                  erro[0], ferr[0], cnt_a, vo[0]);
      end
      yumi_i = 1;
      tick();
      yumi_i = 0;
   endtask

   task automatic test_backpressure();
      v_i = 1; data_i = 32'hA5A5_0001; parity_i = 4'b0;
      tick();
      data_i = 32'h5A5A_0002;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (rdy[0] !== 1'b0 || vo[0] !== 1'b1 || dout[0] !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL backpressure[%0d]: ready=%b v_o=%b data=%h, want 0 1 a5a50001", c, rdy[0], vo[0], dout[0]);
         end
         tick();
      end
      yumi_i = 1;
      #1;
      checks++;
      if (rdy[0] !== 1'b1) begin
         failures++;
         $display("FAIL ready_through_yumi: ready=%b want 1", rdy[0]);
      end
      tick();
      yumi_i = 0; v_i = 0;
      #1;
      checks++;
      if (vo[0] !== 1'b1 || dout[0] !== 32'h5A5A_0002) begin
         failures++;
         $display("FAIL refill: v_o=%b data=%h, want 1 5a5a0002", vo[0], dout[0]);
      end
      yumi_i = 1;
      tick();
      yumi_i = 0;
   endtask

   task automatic test_saturation();
      int exp_cnt[5] = '{1, 2, 3, 3, 3};
      clear_i = 1;
      tick();
      clear_i = 0;
      for (int i = 0; i < 5; i++) begin
         v_i = 1; data_i = 32'h0100FF03; parity_i = 4'b1001; yumi_i = m_v;
         tick();
         v_i = 0; yumi_i = 0;
         #1;
         checks++;
         if (int'(cnt_b) != exp_cnt[i]) begin
            failures++;
            $display("FAIL saturate[%0d]: cnt=%0d want %0d", i, cnt_b, exp_cnt[i]);
         end
      end
      yumi_i = 1;
      tick();
      yumi_i = 0; clear_i = 1;
      tick();
      clear_i = 0;
      #1;
      checks++;
      if (cnt_b !== 2'd0 || stk[1] !== 1'b0 || ferr[1] !== 4'b0) begin
         failures++;
         $display("FAIL clear: cnt=%0d sticky=%b first=%b, want 0 0 0000", cnt_b, stk[1], ferr[1]);
      end
      clear_i = 1; v_i = 1; data_i = 32'h0100FF03; parity_i = 4'b1100;
      tick();
      clear_i = 0; v_i = 0;
      #1;
      checks++;
      if (cnt_b !== 2'd1 || stk[1] !== 1'b1 || ferr[1] !== 4'b0100) begin
         failures++;
         $display("FAIL clear_with_err: cnt=%0d sticky=%b first=%b, want 1 1 0100", cnt_b, stk[1], ferr[1]);
      end
      yumi_i = 1;
      tick();
      yumi_i = 0;
   endtask

   task automatic test_odd();
      v_i = 1; data_i = 32'h0; parity_i = 4'b0001;
      tick();
      v_i = 0;
      #1;
      checks++;
      if (erro[2][0] !== 1'b0 || erro[0][0] !== 1'b1) begin
         failures++;
         $display("FAIL odd_par1: odd err0=%b even err0=%b, want 0 1", erro[2][0], erro[0][0]);
      end
      yumi_i = 1; v_i = 1; parity_i = 4'b0000;
      tick();
      yumi_i = 0; v_i = 0;
      #1;
      checks++;
      if (erro[2][0] !== 1'b1 || erro[0][0] !== 1'b0) begin
         failures++;
         $display("FAIL odd_par0: odd err0=%b even err0=%b, want 1 0", erro[2][0], erro[0][0]);
      end
      yumi_i = 1;
      tick();
      yumi_i = 0;
   endtask

   task automatic test_random_stream();
      logic [31:0] sent[$];
      logic [31:0] got[$];
      bit pending = 0;
      int nsent = 0;
      int cyc = 0;
      bit acc;
      while (got.size() < 100 && cyc < 3000) begin
         if (!pending && nsent < 100 && $urandom_range(0, 3) != 0) begin
            pending = 1;
            data_i = $urandom; parity_i = 4'($urandom_range(0, 15));
         end
         v_i = pending;
         clear_i = ($urandom_range(0, 19) == 0);
         yumi_i = m_v && ($urandom_range(0, 1) == 1);
         #1;
         checks++;
         if (rdy[0] !== (!m_v || yumi_i)) begin
            failures++;
            $display("FAIL rand_ready cyc%0d: ready=%b want %b", cyc, rdy[0], (!m_v || yumi_i));
         end
         if (yumi_i) begin
            got.push_back(dout[0]);
            for (int k = 0; k < 3; k++) begin
               checks++;
               if (dout[k] !== m_data || erro[k] !== m_err[k]) begin
                  failures++;
                  $display("FAIL rand_word[%0d] cyc%0d: data=%h err=%b, want %h %b", k, cyc, dout[k], erro[k], m_data, m_err[k]);
               end
            end
         end
         acc = pending && (!m_v || yumi_i);
         if (acc) begin
            sent.push_back(data_i); pending = 0; nsent++;
         end
         tick();
         v_i = 0; yumi_i = 0; clear_i = 0;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (vo[k] !== m_v || stk[k] !== m_sticky[k] || ferr[k] !== m_first[k] || cnt_of(k) != m_cnt[k]) begin
               failures++;
               $display("FAIL rand_stats[%0d] cyc%0d: v=%b sticky=%b first=%b cnt=%0d, want %b %b %b %0d",
                        k, cyc, vo[k], stk[k], ferr[k], cnt_of(k), m_v, m_sticky[k], m_first[k], m_cnt[k]);
            end
         end
         cyc++;
      end
      checks++;
      if (got.size() != 100 || sent.size() != 100) begin
         failures++;
         $display("FAIL rand_count: received=%0d sent=%0d want 100 100", got.size(), sent.size());
      end else begin
         for (int i = 0; i < 100; i++) begin
            checks++;
            if (got[i] !== sent[i]) begin
               failures++;
               $display("FAIL rand_order[%0d]: got=%h want %h", i, got[i], sent[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      v_i = 1; data_i = 32'h0100FF03; parity_i = 4'b1001;
      tick();
      checks++;
      if (vo[0] !== 1'b1 || stk[0] !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_setup: v_o=%b sticky=%b want 1 1", vo[0], stk[0]);
      end
      reset_i = 1; clear_i = 1;
      tick();
      reset_i = 0; clear_i = 0; v_i = 0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (vo[k] !== 1'b0 || stk[k] !== 1'b0 || cnt_of(k) != 0 || rdy[k] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid[%0d]: v_o=%b sticky=%b cnt=%0d ready=%b, want 0 0 0 1",
                     k, vo[k], stk[k], cnt_of(k), rdy[k]);
         end
      end
   endtask

   initial begin
      reset_i = 1; v_i = 0; yumi_i = 0; clear_i = 0; data_i = '0; parity_i = '0;
      m_v = 0; m_data = '0;
      for (int k = 0; k < 3; k++) begin
         m_err[k] = '0; m_sticky[k] = 0; m_first[k] = '0; m_cnt[k] = 0;
      end
      test_reset();
      test_clean_word();
      test_error_words();
      test_backpressure();
      test_saturation();
      test_odd();
      test_random_stream();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
